// File: rtl/blk_transpose.sv
// 8x8 block transposer: rows in, columns out, through a ping-pong pair of banks.
// Writer validates row framing; reader drains committed banks column by column.
module blk_transpose #(
    parameter int unsigned W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0][W-1:0]  in_data,
    input  logic               in_sob,
    input  logic               in_eob,
    input  logic               in_sof,
    output logic               out_valid,
    output logic [7:0][W-1:0]  out_data,
    output logic               out_sob,
    output logic               out_eob,
    output logic               out_sof,
    output logic               err
);

    typedef enum logic [0:0] {StIdle, StRead} rd_state_e;

    // Bank storage, no reset needed: full flags gate every read.
    logic [7:0][W-1:0] mem_q [2][8];

    logic [2:0] wr_row_q, wr_row_d;
    logic       in_blk_q, in_blk_d;
    logic       sof_cap_q, sof_cap_d;
    logic       wb_q, wb_d;
    logic       rb_q, rb_d;
    logic [1:0] full_q, full_d;
    logic [1:0] sof_bank_q, sof_bank_d;
    logic       err_q, err_d;

    rd_state_e  state_q, state_d;
    logic [2:0] col_q, col_d;

    logic              out_valid_q, out_valid_d;
    logic [7:0][W-1:0] out_data_q, out_data_d;
    logic              out_sob_q, out_sob_d;
    logic              out_eob_q, out_eob_d;
    logic              out_sof_q, out_sof_d;

    logic       mem_we;
    logic [2:0] mem_row;
    logic       commit;
    logic       clr;
    logic       emit;
    logic [2:0] emit_col;

    // Writer: framing checks and row placement.
    always_comb begin
        wr_row_d   = wr_row_q;
        in_blk_d   = in_blk_q;
        sof_cap_d  = sof_cap_q;
        wb_d       = wb_q;
        sof_bank_d = sof_bank_q;
        err_d      = 1'b0;
        mem_we     = 1'b0;
        mem_row    = 3'd0;
        commit     = 1'b0;
        if (in_valid) begin
            if (in_sob) begin
                // A sob beat always restarts at row 0, even after a violation.
                err_d     = in_blk_q | in_eob;
                mem_we    = 1'b1;
                mem_row   = 3'd0;
                sof_cap_d = in_sof;
                in_blk_d  = ~in_eob;
                wr_row_d  = in_eob ? 3'd0 : 3'd1;
            end else if (!in_blk_q) begin
                err_d = 1'b1;
            end else if (wr_row_q == 3'd7) begin
                in_blk_d = 1'b0;
                wr_row_d = 3'd0;
                if (in_eob) begin
                    mem_we            = 1'b1;
                    mem_row           = 3'd7;
                    commit            = 1'b1;
                    sof_bank_d[wb_q]  = sof_cap_q;
                    wb_d              = ~wb_q;
                end else begin
                    err_d = 1'b1;
                end
            end else if (in_eob) begin
                err_d    = 1'b1;
                in_blk_d = 1'b0;
                wr_row_d = 3'd0;
            end else begin
                mem_we   = 1'b1;
                mem_row  = wr_row_q;
                wr_row_d = wr_row_q + 3'd1;
            end
        end
    end

    // Reader: idle emits column 0 directly so commit-to-output latency is two cycles.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        rb_d        = rb_q;
        clr         = 1'b0;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        out_sob_d   = 1'b0;
        out_eob_d   = 1'b0;
        out_sof_d   = 1'b0;
        emit        = (state_q == StRead) || full_q[rb_q];
        emit_col    = (state_q == StRead) ? col_q : 3'd0;
        if (emit) begin
            out_valid_d = 1'b1;
            for (int r = 0; r < 8; r++) begin
                out_data_d[r] = mem_q[rb_q][r][emit_col];
            end
            out_sob_d = (emit_col == 3'd0);
            out_eob_d = (emit_col == 3'd7);
            out_sof_d = (emit_col == 3'd0) && sof_bank_q[rb_q];
            if (emit_col == 3'd7) begin
                clr     = 1'b1;
                rb_d    = ~rb_q;
                col_d   = 3'd0;
                state_d = full_q[~rb_q] ? StRead : StIdle;
            end else begin
                col_d   = emit_col + 3'd1;
                state_d = StRead;
            end
        end
    end

    always_comb begin
        full_d = full_q;
        if (clr) begin
            full_d[rb_q] = 1'b0;
        end
        if (commit) begin
            full_d[wb_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wb_q][mem_row] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_row_q    <= 3'd0;
            in_blk_q    <= 1'b0;
            sof_cap_q   <= 1'b0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            full_q      <= 2'b00;
            sof_bank_q  <= 2'b00;
            err_q       <= 1'b0;
            state_q     <= StIdle;
            col_q       <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sob_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_sof_q   <= 1'b0;
        end else begin
            wr_row_q    <= wr_row_d;
            in_blk_q    <= in_blk_d;
            sof_cap_q   <= sof_cap_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            full_q      <= full_d;
            sof_bank_q  <= sof_bank_d;
            err_q       <= err_d;
            state_q     <= state_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sob_q   <= out_sob_d;
            out_eob_q   <= out_eob_d;
            out_sof_q   <= out_sof_d;
        end
    end

    // The writer can never outrun the reader at one row per cycle.
    assert property (@(posedge clk) disable iff (rst) commit |-> !full_q[wb_q]);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sob   = out_sob_q;
    assign out_eob   = out_eob_q;
    assign out_sof   = out_sof_q;
    assign err       = err_q;

endmodule

// File: tb/tb_blk_transpose.sv
// Scoreboard bench for blk_transpose: expected columns and their cycle are queued
// when the eob row is driven and compared as the DUT emits them.
module tb_blk_transpose;

    localparam int W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0][W-1:0] in_data;
    logic              in_sob;
    logic              in_eob;
    logic              in_sof;
    logic              out_valid;
    logic [7:0][W-1:0] out_data;
    logic              out_sob;
    logic              out_eob;
    logic              out_sof;
    logic              err;

    blk_transpose #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_sob   (in_sob),
        .in_eob   (in_eob),
        .in_sof   (in_sof),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_sob  (out_sob),
        .out_eob  (out_eob),
        .out_sof  (out_sof),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        sob;
        logic        eob;
        logic        sof;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    int   next_free = 0;
    logic viol_drv  = 1'b0;
    logic err_exp   = 1'b0;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        err_exp <= !rst && in_valid && viol_drv;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_checks++;
        if (obs === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
        end
    endtask

    function automatic logic [63:0] row_val(input int base, input int r);
        logic [7:0][7:0] v;
        for (int c = 0; c < 8; c++) v[c] = 8'(base + 8 * r + c);
        return v;
    endfunction

    function automatic logic [63:0] col_val(input int base, input int c);
        logic [7:0][7:0] v;
        for (int r = 0; r < 8; r++) v[r] = 8'(base + 8 * r + c);
        return v;
    endfunction

    task automatic push_block(input int base, input logic sof, input int eob_cyc,
                              output int start);
        exp_t e;
        start = (eob_cyc + 2 > next_free) ? eob_cyc + 2 : next_free;
        for (int c = 0; c < 8; c++) begin
            e.data = col_val(base, c);
            e.sob  = (c == 0);
            e.eob  = (c == 7);
            e.sof  = sof && (c == 0);
            e.cyc  = start + c;
            sb.push_back(e);
        end
        next_free = start + 8;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_row(input logic [63:0] d, input logic sob, input logic eob,
                            input logic sof, input logic viol);
        in_valid = 1'b1;
        in_data  = d;
        in_sob   = sob;
        in_eob   = eob;
        in_sof   = sof;
        viol_drv = viol;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sob   = 1'b0;
        in_eob   = 1'b0;
        in_sof   = 1'b0;
        viol_drv = 1'b0;
    endtask

    task automatic send_block(input int base, input logic sof, input int maxgap,
                              input logic viol0, output int start);
        int ec;
        ec = 0;
        for (int r = 0; r < 8; r++) begin
            if (r > 0 && maxgap > 0) idle(int'($urandom_range(1, maxgap)));
            if (r == 7) ec = cyc;
            send_row(row_val(base, r), r == 0, r == 7, sof && r == 0, viol0 && r == 0);
        end
        push_block(base, sof, ec, start);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_valid"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_data"}, 64'(out_data), 64'd0);
        check_eq({tag, "_side"}, 64'({out_sob, out_eob, out_sof}), 64'd0);
        check_eq({tag, "_err"}, 64'(err), 64'd0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        check_eq("err", 64'(err), 64'(err_exp));
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("col_data", 64'(out_data), e.data);
                check_eq("col_sob", 64'(out_sob), 64'(e.sob));
                check_eq("col_eob", 64'(out_eob), 64'(e.eob));
                check_eq("col_sof", 64'(out_sof), 64'(e.sof));
                check_eq("col_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            check_eq("idle_side", 64'({out_sob, out_eob, out_sof}), 64'd0);
        end
    end

    initial begin
        int st;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sob   = 1'b0;
        in_eob   = 1'b0;
        in_sof   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Single clean block, then three back-to-back blocks with sof on the first.
        send_block(0, 1'b0, 0, 1'b0, st);
        idle(12);
        send_block(64, 1'b1, 0, 1'b0, st);
        send_block(128, 1'b0, 0, 1'b0, st);
        send_block(192, 1'b0, 0, 1'b0, st);
        idle(30);

        // Gaps of 1-3 idle cycles between rows.
        send_block(0, 1'b0, 3, 1'b0, st);
        idle(12);

        // eob on row 5: block dropped, next clean block passes.
        for (int r = 0; r < 6; r++) send_row(row_val(17, r), r == 0, r == 5, 1'b0, r == 5);
        send_block(33, 1'b0, 0, 1'b0, st);
        idle(12);

        // New sob at row 4: first block dropped, second starts at that beat.
        for (int r = 0; r < 4; r++) send_row(row_val(50, r), r == 0, 1'b0, 1'b0, 1'b0);
        send_block(90, 1'b1, 0, 1'b1, st);
        idle(12);

        // Stray beat outside a block, then row 7 missing eob.
        send_row(row_val(3, 2), 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        for (int r = 0; r < 8; r++) send_row(row_val(40, r), r == 0, 1'b0, 1'b0, r == 7);
        send_block(140, 1'b0, 0, 1'b0, st);
        idle(20);

        // Reset during column 3 of a read discards the rest of the block.
        send_block(7, 1'b0, 0, 1'b0, st);
        while (cyc < st + 3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        next_free = 0;
        @(negedge clk);
        check_quiet("post_rst");
        @(posedge clk);
        #1;
        idle(12);
        send_block(99, 1'b1, 0, 1'b0, st);

        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        check_eq("drain", 64'(sb.size()), 64'd0);
        idle(4);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/blk_transpose.md
BLK_TRANSPOSE -- requirements
Module: blk_transpose

Interface
REQ-001 W, default 8, width in bits of one sample in the data bus.
REQ-002 clk  input  1  rising-edge clock, the block's only clock.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  row beat valid.
REQ-005 in_data  input  [7:0][W-1:0]  one 8-sample row; in_data[i] is sample i of the row.
REQ-006 in_sob / in_eob / in_sof  input  1 each  start-of-block, end-of-block, start-of-frame; qualified by in_valid.
REQ-007 out_valid  output  1  column beat valid.
REQ-008 out_data  output  [7:0][W-1:0]  one column; out_data[r] = sample from row r.
REQ-009 out_sob / out_eob / out_sof  output  1 each  block framing for the transposed stream.
REQ-010 err  output  1  one-cycle pulse on an input framing violation.

Function
REQ-011 The block SHALL accept 8x8 blocks as 8 row beats (row 0 with in_sob, row 7 with in_eob) and emit each block as 8 column beats, column c carrying element [r][c] of row r in out_data[r].
REQ-012 Storage SHALL be two 8x8xW banks (ping-pong): the writer fills bank wb while the reader drains the other bank; wb and rb both reset to bank 0.
REQ-013 Writer state: wr_row (0..7) and in_blk flag. A valid beat with in_sob SHALL be stored as row 0, set in_blk, set wr_row=1.
REQ-014 A valid beat without in_sob while in_blk=1 SHALL be stored at wr_row; wr_row increments.
REQ-015 The row-7 beat with in_eob SHALL commit the bank: full[wb]<=1, wb toggles, in_blk<=0, and the block's sof flag (in_sof captured on its row-0 beat) is stored per bank.
REQ-016 Violations: in_sob beat while in_blk=1; non-sob beat while in_blk=0; in_eob on a row other than 7; row 7 without in_eob. Each SHALL pulse err in the following cycle. The current partial block SHALL be discarded (in_blk<=0, no commit). In the in_sob case, a new block SHALL start at row 0 with that beat.
REQ-017 Reader FSM states IDLE and READ. IDLE->READ when full[rb]=1. READ emits columns 0..7 on consecutive cycles.
REQ-018 After column 7 the reader SHALL clear full[rb] and toggle rb. If the other bank is full, it SHALL stay in READ and emit column 0 on the next cycle (no bubble); otherwise it SHALL go to IDLE.
REQ-019 Latency: if the row-7/eob beat is presented in cycle n into an idle reader, column 0 SHALL be presented in cycle n+2.
REQ-020 out_sob SHALL be high on column 0 only; out_eob on column 7 only; out_sof on column 0 only when the stored sof of that bank is 1; all sidebands are 0 when out_valid=0.
REQ-021 All outputs SHALL be registered. out_data SHALL hold its last value while out_valid=0.
REQ-022 At one row per cycle maximum input rate the writer never targets a full bank. A simulation assertion SHALL flag a commit into a bank with full=1; no RTL recovery is required.
REQ-023 Gaps (in_valid=0) inside a block SHALL be allowed and SHALL not affect content or framing.

Reset
REQ-024 While rst=1: out_valid, out_sob, out_eob, out_sof and err SHALL be 0, and out_data SHALL be 0. wr_row=0, in_blk=0, full[1:0]=0, wb=rb=0, and the reader SHALL be in IDLE.
REQ-025 Bank contents SHALL not require reset.
REQ-026 Reset asserted mid-block or mid-read SHALL discard all buffered data. No column beat SHALL appear after reset until a new complete block is committed.

Verification
REQ-027 Single block, row r sample c = 8r+c, with sob on row 0, eob on row 7, in cycles 0..7 -> columns in cycles 9..16. Column c has out_data[r]=8r+c. out_sob in cycle 9, out_eob in cycle 16, err never asserted.
REQ-028 Three back-to-back blocks (24 consecutive beats, sof on first block) -> 24 consecutive column beats with no gap. out_sof only on the first column 0. Each block is transposed correctly.
REQ-029 Block with in_valid gaps of 1-3 cycles between rows -> output identical to REQ-027 content, starting 2 cycles after the eob beat.
REQ-030 in_eob on row 5 -> err pulse the next cycle, no output for that block. The following clean block is output normally.
REQ-031 New in_sob at row 4 of a block -> err pulse. The first block is dropped; the second block (starting at that beat) is output correctly.
REQ-032 rst asserted for 1 cycle during column 3 of a read -> out_valid=0 from the next cycle. No further columns appear. A subsequent block is output with REQ-019 latency.
